// File: rtl/gb_bus_pkg.sv
// Shared system-bus definitions: fixed addresses, the OAM DMA state encoding
// and the echo-RAM page remap used when latching a DMA source page.
package gb_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } dma_state_t;

  // Pages E0..FF mirror WRAM at C0..DF, so the DMA reads the backing RAM.
  function automatic logic [7:0] echo_page(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer behind FF46: copies LENGTH bytes from {page, 00} into OAM
// while owning the read bus and blocking non-HRAM CPU accesses.
module oam_dma_ctrl
  import gb_bus_pkg::*;
#(
  parameter int LENGTH      = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [7:0]  reg_in,
  output logic [7:0]  reg_out,
  input  logic [15:0] cpu_addr,
  output logic        cpu_blocked,
  output logic        dma_active,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_write
);

  localparam int              DW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [7:0]      LAST_IDX   = 8'(LENGTH - 1);
  localparam logic [DW-1:0]   DELAY_INIT = DW'(START_DELAY - 1);

  dma_state_t    state;
  dma_state_t    state_next;
  logic [7:0]    page;
  logic [7:0]    idx;
  logic [7:0]    wr_idx;
  logic          wr_pend;
  logic [DW-1:0] delay;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state is defaulted before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = IDLE;
      START:   if (delay == '0)     state_next = XFER;
      XFER:    if (idx == LAST_IDX) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A register write restarts from any state, including the final DRAIN.
    if (reg_write) state_next = START;
  end

  // src_addr is loaded one step ahead so it shows {page, idx} during each
  // XFER cycle; the byte read there is written to OAM on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      page     <= 8'h00;
      reg_out  <= 8'hFF;
      idx      <= 8'h00;
      delay    <= '0;
      src_addr <= 16'h0000;
      wr_idx   <= 8'h00;
      wr_pend  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (reg_write) begin
        page    <= echo_page(reg_in);
        reg_out <= reg_in;
        delay   <= DELAY_INIT;
        idx     <= 8'h00;
      end else begin
        unique case (state)
          START: begin
            if (delay == '0) begin
              idx      <= 8'h00;
              src_addr <= {page, 8'h00};
            end else begin
              delay <= delay - 1'b1;
            end
          end
          XFER: begin
            wr_pend <= 1'b1;
            wr_idx  <= idx;
            if (idx != LAST_IDX) begin
              idx      <= idx + 8'd1;
              src_addr <= {page, idx + 8'd1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dma_active  = (state != IDLE);
  assign cpu_blocked = dma_active && (cpu_addr < HRAM_BASE) && (cpu_addr != DMA_REG_ADDR);

  // Write port is idle-zero so outputs match their reset values between writes.
  assign oam_write = wr_pend;
  assign oam_addr  = wr_pend ? wr_idx   : 8'h00;
  assign oam_data  = wr_pend ? src_data : 8'h00;

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the OAM DMA engine behind register FF46. A CPU write of a source page copies LENGTH bytes from {page, 8'h00} into OAM.
- While the copy runs, the block owns the system read bus. It also flags CPU accesses outside HRAM as blocked, so the top-level decoder returns 8'hFF to the CPU.
- Clocked by the CPU clock. Sits beside the bus decoder in top and drives the OAM write port of the PPU.

Parameters:
- LENGTH, 160, bytes per transfer (1..256).
- START_DELAY, 1, cycles between the FF46 write and the first source read (>=1).

Ports:
- clk  input  1  CPU clock.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  strobe: the CPU is writing FF46 this cycle.
- reg_in  input  8  CPU write data (source page).
- reg_out  output  8  FF46 readback (last value written).
- cpu_addr  input  16  current CPU address.
- cpu_blocked  output  1  CPU access must be ignored (reads return FF, writes dropped).
- dma_active  output  1  transfer in progress; the bus decoder routes src_addr instead of cpu_addr.
- src_addr  output  16  DMA source address on the system bus.
- src_data  input  8  read data. Valid exactly one cycle after src_addr is presented.
- oam_addr  output  8  OAM write index.
- oam_data  output  8  OAM write data.
- oam_write  output  1  OAM write enable.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high (port names clk, rst).
- Reset values:
  - state IDLE; dma_active 0; cpu_blocked 0; oam_write 0.
  - reg_out 8'hFF; src_addr 16'h0000; oam_addr 0; oam_data 0; index counter 0.
- States: IDLE, START, XFER, DRAIN.
- IDLE:
  - reg_write=1 latches page <= reg_in and reg_out <= reg_in.
  - Next cycle enters START with delay counter = START_DELAY-1.
- START: counts down; at 0 enters XFER with idx=0.
- XFER:
  - Each cycle drives src_addr = {eff_page, idx}, then idx <= idx+1.
  - When idx reaches LENGTH-1, the next state is DRAIN.
- Write pipeline, active in XFER (except its first cycle) and in DRAIN:
  - oam_write=1, oam_addr = previous idx, oam_data = src_data.
  - DRAIN performs the final write, then returns to IDLE.
- eff_page:
  - page if page < 8'hE0; otherwise page - 8'h20 (echo to WRAM).
  - Computed at latch time and held for the whole transfer.
- Timing: dma_active=1 throughout START, XFER and DRAIN. Total active length = START_DELAY + LENGTH + 1 cycles.
- cpu_blocked = dma_active && !(cpu_addr[15:7] == 9'h1FF). HRAM (FF80-FFFF) stays accessible to the CPU. FF46 itself is not blocked, so restarts remain possible.
- Restart: reg_write in any non-IDLE state relatches page/reg_out and re-enters START with idx=0.
  - A write pending in the pipeline that cycle is still issued.
  - The new transfer then overwrites OAM from index 0.
- Simultaneous reg_write and final DRAIN cycle: the final write completes and the state goes to START (restart wins over IDLE).
- Reset mid-transfer:
  - All outputs return to reset values the next cycle.
  - No further oam_write is issued.
  - OAM keeps the partially written contents.
- Width rules: idx is 8 bits and never wraps within a transfer (LENGTH <= 256). oam_addr = idx-1 truncated to 8 bits.
- src_addr holds its last value outside XFER. The decoder ignores it when dma_active=0 or the state is not XFER.

Decomposition:
- Shared package gb_bus_pkg holds:
  - address constants DMA_REG_ADDR = 16'hFF46, HRAM_BASE = 16'hFF80, OAM_BASE = 16'hFE00;
  - the dma_state_t enum (IDLE, START, XFER, DRAIN).
- Single module, no sub-module. The page echo remap is an inline function in the package.

Test Plan:
1. Basic: reset, write 8'hC1. Required:
   - src_addr C100..C19F on consecutive cycles.
   - oam_write for idx 0..159 with oam_data equal to the model memory.
   - dma_active high for exactly 162 cycles.
2. Echo: write 8'hE3. Required: src_addr runs C300..C39F; reg_out reads 8'hE3.
3. Blocking: during a transfer, cpu_addr=16'hC000 -> cpu_blocked=1; 16'hFF90 -> 0; 16'hFF46 -> 0. After DRAIN, 16'hC000 -> 0.
4. Restart: write 8'hC1, then write 8'hD0 after 50 XFER cycles. Required:
   - one pending write for index 49 still issued;
   - the transfer restarts at D000 and completes to D09F;
   - final OAM contents come from D0xx.
5. Reset mid-transfer: assert rst at XFER idx=80. Required:
   - next cycle dma_active=0, oam_write=0, reg_out=8'hFF;
   - no further writes;
   - a later write 8'hC2 runs a full clean transfer.
6. Back-to-back: new reg_write coinciding with the DRAIN cycle of a previous transfer. Required: the last write (oam_addr 159) is issued, the next cycle is START, and dma_active never drops.
